// File: rtl/operand_fetch_stage.sv
// Register file plus one-entry operand register in front of the ALU, with writeback forwarding.
// Define OPERAND_FETCH_ZERO_R0_EN to hardwire register 0 to zero.
module operand_fetch_stage #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [ADDR_W-1:0] rd_out,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

`ifdef OPERAND_FETCH_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and the issue side is ready whenever the held pair is empty or leaving.

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [ADDR_W-1:0] src1_q, src2_q;
  logic [DATA_W-1:0] rf_rs1, rf_rs2, fwd1, fwd2;
  logic              accept, hit1, hit2, ref1, ref2;

  // True when the writeback this cycle targets an existing, writable register a.
  function automatic logic wb_hits(input logic [ADDR_W-1:0] a,
                                   input logic              en,
                                   input logic [ADDR_W-1:0] wa);
    logic h;
    h = en && (wa == a) && (int'(a) < NUM_REGS);
    if (ZERO_R0 && (a == '0)) h = 1'b0;
    return h;
  endfunction

  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs1 == ADDR_W'(i)) rf_rs1 = rf[i];
      if (rs2 == ADDR_W'(i)) rf_rs2 = rf[i];
    end
  end

  assign hit1        = wb_hits(rs1, wb_en, wb_addr);
  assign hit2        = wb_hits(rs2, wb_en, wb_addr);
  assign ref1        = wb_hits(src1_q, wb_en, wb_addr);
  assign ref2        = wb_hits(src2_q, wb_en, wb_addr);
  assign fwd1        = hit1 ? wb_data : rf_rs1;
  assign fwd2        = hit2 ? wb_data : rf_rs2;
  assign issue_ready = !out_valid || out_ready;
  assign accept      = issue_valid && issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data1     <= '0;
      data2     <= '0;
      rd_out    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data1     <= fwd1;
      data2     <= fwd2;
      rd_out    <= rd_in;
      src1_q    <= rs1;
      src2_q    <= rs2;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Keep a held operand in step with its source register while waiting.
      if (out_valid && ref1) data1 <= wb_data;
      if (out_valid && ref2) data2 <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && (wb_addr == ADDR_W'(i)) && !(ZERO_R0 && (i == 0)))
          rf[i] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, async reset sequence, random run vs model.
module tb_operand_fetch_stage;

`ifdef OPERAND_FETCH_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
  logic [2:0] rs1 = '0, rs2 = '0, rd_in = '0, wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic       issue_ready, out_valid;
  logic [7:0] data1, data2;
  logic [2:0] rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  operand_fetch_stage #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data1(data1), .data2(data2), .rd_out(rd_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [2:0] rs1, rs2, rd;
    logic       ordy, we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rdy;
    logic       ov;
    logic [7:0] d1, d2;
    logic [2:0] rdo;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];   // {rd, src1, src2} of the pair the stage should be holding
  logic [7:0] m_rf [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [2:0] rd, input logic ordy, input logic we,
                       input logic [2:0] wa, input logic [7:0] wd);
    issue_valid = iv; rs1 = a1; rs2 = a2; rd_in = rd;
    out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  function automatic void add(input logic iv, input logic [2:0] a1, input logic [2:0] a2,
                              input logic [2:0] rd, input logic ordy, input logic we,
                              input logic [2:0] wa, input logic [7:0] wd, input logic rdy,
                              input logic ov, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [2:0] rdo);
    vec_t v;
    v.iv = iv; v.rs1 = a1; v.rs2 = a2; v.rd = rd; v.ordy = ordy; v.we = we;
    v.wa = wa; v.wd = wd; v.rdy = rdy; v.ov = ov; v.d1 = d1; v.d2 = d2; v.rdo = rdo;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] r0v, r0ff, r011, r033;
    logic [7:0] b2b [4];
    logic       exp_rdy;
    logic [8:0] e;

    r0v  = ZERO_R0 ? 8'h00 : 8'h01;
    r0ff = ZERO_R0 ? 8'h00 : 8'hFF;
    r011 = ZERO_R0 ? 8'h00 : 8'h11;
    r033 = ZERO_R0 ? 8'h00 : 8'h33;
    b2b[0] = r0v; b2b[1] = 8'h02; b2b[2] = 8'h03; b2b[3] = 8'h5C;

    // Reset state
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data1", data1, 8'h00);
    check("rst_data2", data2, 8'h00);
    check("rst_rd_out", rd_out, 3'd0);
    check("rst_issue_ready", issue_ready, 1'b1);
    rst = 1'b0;
    step();

    // Directed table: preload, issue, forward, stall refresh, back-to-back, r0 behaviour
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 0, 0, 1, 3'(i), 8'(i + 1), 1, 0, 8'h00, 8'h00, 3'd0);
    add(1, 2, 5, 7, 1, 0, 0, 8'h00, 1, 1, 8'h03, 8'h06, 3'd7);
    add(1, 4, 4, 1, 1, 1, 4, 8'hAA, 1, 1, 8'hAA, 8'hAA, 3'd1);
    add(1, 3, 6, 2, 1, 0, 0, 8'h00, 1, 1, 8'h04, 8'h07, 3'd2);
    add(1, 0, 0, 5, 0, 1, 3, 8'h5C, 0, 1, 8'h5C, 8'h07, 3'd2);
    add(0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 8'h5C, 8'h07, 3'd2);
    for (int i = 0; i < 4; i++)
      add(1, 3'(i), 4, 3'(i), 1, 0, 0, 8'h00, 1, 1, b2b[i], 8'hAA, 3'(i));
    add(0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 8'h5C, 8'hAA, 3'd3);
    add(0, 0, 0, 0, 0, 1, 0, 8'hFF, 1, 0, 8'h5C, 8'hAA, 3'd3);
    add(1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 1, r0ff, 8'h02, 3'd0);
    add(1, 0, 0, 6, 1, 1, 0, 8'h11, 1, 1, r011, r011, 3'd6);
    add(0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0, r011, r011, 3'd6);
    add(1, 0, 7, 4, 0, 0, 0, 8'h00, 1, 1, r011, 8'h08, 3'd4);
    add(0, 0, 0, 0, 0, 1, 0, 8'h33, 0, 1, r033, 8'h08, 3'd4);
    add(0, 0, 0, 0, 1, 1, 7, 8'h44, 1, 0, r033, 8'h44, 3'd4);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].ordy, vecs[i].we, vecs[i].wa, vecs[i].wd);
      #1;
      check($sformatf("vec%0d_issue_ready", i), issue_ready, vecs[i].rdy);
      step();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("vec%0d_data1", i), data1, vecs[i].d1);
      check($sformatf("vec%0d_data2", i), data2, vecs[i].d2);
      check($sformatf("vec%0d_rd_out", i), rd_out, vecs[i].rdo);
    end

    // Asynchronous reset in the middle of a stall
    drive(1, 2, 5, 3, 0, 0, 0, 8'h00);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    check("stall_out_valid", out_valid, 1'b1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_data1", data1, 8'h00);
    check("arst_data2", data2, 8'h00);
    check("arst_rd_out", rd_out, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 2, 5, 1, 1, 0, 0, 8'h00);
    step();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_data1", data1, 8'h00);
    check("post_rst_data2", data2, 8'h00);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
    step();
    check("post_rst_drain", out_valid, 1'b0);

    // Random run against the model: a held pair always mirrors its source registers
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      #1;
      exp_rdy = (exp_q.size() == 0) || out_ready;
      check("rnd_issue_ready", issue_ready, exp_rdy);
      check("rnd_out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("rnd_rd_out", rd_out, e[8:6]);
        check("rnd_data1", data1, m_rf[e[5:3]]);
        check("rnd_data2", data2, m_rf[e[2:0]]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (issue_valid && exp_rdy) exp_q.push_back({rd_in, rs1, rs2});
      if (wb_en && !(ZERO_R0 && wb_addr == 3'd0)) m_rf[wb_addr] = wb_data;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register file plus single-entry operand pipeline register that sits directly upstream of the 8-bit adder ALU.
- Reads two source registers, forwards same-cycle writebacks, and presents registered operands on data1/data2 under a valid/ready handshake.
- Accepts the ALU result path back in as the writeback port.

Parameters:
- DATA_W, 8, operand and register width; matches ALU data1/data2/out.
- NUM_REGS, 8, number of architectural registers.
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  upstream presents rs1/rs2/rd_in.
- issue_ready  output  1  stage can accept an issue this cycle.
- rs1  input  ADDR_W  source address for data1.
- rs2  input  ADDR_W  source address for data2.
- rd_in  input  ADDR_W  destination tag, carried alongside the operands.
- out_valid  output  1  data1/data2/rd_out hold a valid operand pair.
- out_ready  input  1  ALU/downstream consumes the pair this cycle.
- data1  output  DATA_W  registered operand 1 to the ALU.
- data2  output  DATA_W  registered operand 2 to the ALU.
- rd_out  output  ADDR_W  registered destination tag.
- wb_en  input  1  write enable for the register file.
- wb_addr  input  ADDR_W  write address.
- wb_data  input  DATA_W  write data, normally the ALU out.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: all NUM_REGS registers=0, out_valid=0, data1=data2=0, rd_out=0, captured source addresses=0. Reset mid-handshake drops the held pair with no output.
- issue_ready = !out_valid || out_ready. This is combinational, with no dependency on issue_valid.
- Accept: issue_valid && issue_ready at a rising edge.
  - data1 <= fwd(rs1) and data2 <= fwd(rs2).
  - rd_out <= rd_in; out_valid <= 1.
  - rs1/rs2 are latched internally as src1_q/src2_q.
  - Latency is 1 cycle from accept to out_valid.
- fwd(a) = wb_data if wb_en && wb_addr==a, else rf[a]. Forwarding is write-before-read in the same cycle.
- Consume without a new accept (out_valid && out_ready && !(issue_valid)) gives out_valid <= 0. data1/data2/rd_out keep their last values.
- Simultaneous consume and accept: the new pair loads and out_valid stays 1. This gives full throughput of one pair per cycle.
- Stall (out_valid && !out_ready): data1/data2/rd_out are stable, except for stall refresh:
  - If wb_en && wb_addr==src1_q, then data1 <= wb_data.
  - Likewise for src2_q and data2. Both refresh if both match.
  - Refresh also applies in the consume cycle only when no new accept occurs. In that case the values are irrelevant, but this keeps the logic uniform.
- Register write: if wb_en at the edge, rf[wb_addr] <= wb_data. Writes occur regardless of the handshake state.
- Out-of-range addresses are not possible when NUM_REGS=2^ADDR_W. Otherwise reads of unused addresses return 0 and writes to them are ignored.
- Arithmetic: none. All paths are DATA_W-wide copies with no extension or truncation.

Optional Feature:
- Macro: OPERAND_FETCH_ZERO_R0_EN
- Defined:
  - Register 0 is hardwired to zero. Writes with wb_addr==0 are ignored.
  - fwd(0)=0 even when wb_en && wb_addr==0.
  - Stall refresh never updates an operand whose source is 0.
- Not defined: register 0 is an ordinary writable register, identical to the others.

Test Plan:
- Reset, then rf[0..7] preloaded 1..8 via wb. Issue rs1=2, rs2=5, rd_in=7 with out_ready=1 → next cycle out_valid=1, data1=3, data2=6, rd_out=7, issue_ready=1.
- Same-cycle forward: wb_en=1, wb_addr=4, wb_data=0xAA while issuing rs1=4, rs2=4 → data1=data2=0xAA; rf[4] reads 0xAA afterwards.
- Stall refresh: hold out_ready=0 with data1 sourced from r3 (=4). Write wb r3=0x5C → data1 becomes 0x5C next cycle, data2 unchanged, issue_ready=0, and a new issue is not accepted.
- Back-to-back: issue_valid=1 and out_ready=1 for 4 cycles with rs1=0..3 → four consecutive pairs, out_valid continuously 1, no bubbles.
- Async reset mid-stall: out_valid=1, out_ready=0, assert rst between clock edges → out_valid=0 and data1=0 immediately. rf reads 0 after release.
- Macro defined: wb r0=0xFF, then issue rs1=0 → data1=0x00. Macro undefined: same stimulus → data1=0xFF.
